// File: rtl/proc_io_mailbox.sv
// proc_io_mailbox: bridges the processor's strobe-less word I/O ports to a
// host-side valid/ready stream pair. A change of level on a control bit in
// OutWord2 marks a transfer, so the previous levels are kept in togTx and togAck.
module proc_io_mailbox #(
    parameter int dataW     = 32,
    parameter int FifoDepth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] OutWord1,
    input  logic [dataW-1:0] OutWord2,
    output logic [dataW-1:0] InpWord1,
    output logic [dataW-1:0] InpWord2,
    output logic [dataW-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [dataW-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             overflow
);

    // Depth is a power of two, so the pointers wrap by plain overflow.
    localparam int AW = $clog2(FifoDepth);
    localparam logic [AW:0] FullCnt = (AW+1)'(FifoDepth);

    logic [dataW-1:0] mem [FifoDepth];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [AW:0]      count;
    logic             togTx;
    logic             togAck;
    logic             ovf;
    logic             rxFull;
    logic [dataW-1:0] rxWord;

    logic pushEv;
    logic ackEv;
    logic pop;
    logic pushOk;
    logic drop;
    logic accept;
    logic fifoFull;
    logic [3:0] cnt4;

    // Only bits 31..29 of the control word carry meaning.
    logic unusedCtrlBits;
    assign unusedCtrlBits = ^OutWord2[28:0];

    assign fifoFull = (count == FullCnt);
    assign pushEv   = OutWord2[31] ^ togTx;
    assign ackEv    = OutWord2[30] ^ togAck;
    assign pop      = tx_valid && tx_ready;
    // A pop on the same edge frees the slot, so a full FIFO still takes the word.
    assign pushOk   = pushEv && (!fifoFull || pop);
    assign drop     = pushEv && !pushOk;
    assign accept   = rx_valid && !rxFull;

    // Remember last control levels so the next edge can detect a toggle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            togTx  <= 1'b0;
            togAck <= 1'b0;
        end else begin
            togTx  <= OutWord2[31];
            togAck <= OutWord2[30];
        end
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                mem[wrPtr] <= OutWord1;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({pushOk, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop on the clearing edge keeps it set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (OutWord2[29]) begin
            ovf <= 1'b0;
        end
    end

    // RX holding register; accept and ack are exclusive since rx_ready is low while full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxWord <= '0;
            rxFull <= 1'b0;
        end else if (accept) begin
            rxWord <= rx_data;
            rxFull <= 1'b1;
        end else if (ackEv && rxFull) begin
            rxFull <= 1'b0;
        end
    end

    assign cnt4     = 4'(count);
    assign tx_valid = (count != '0);
    assign tx_data  = mem[rdPtr];
    assign rx_ready = !rxFull;
    assign overflow = ovf;
    assign InpWord1 = rxWord;
    assign InpWord2 = {{(dataW-8){1'b0}}, cnt4, togTx, ovf, fifoFull, rxFull};

endmodule

// File: tb/tb_proc_io_mailbox.sv
// Bench for proc_io_mailbox: directed scenarios plus random traffic, checked
// against a queue-based model of the mailbox behaviour.
module tb_proc_io_mailbox;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ow1 = '0;
    logic [31:0] ow2 = '0;
    logic [31:0] InpWord1;
    logic [31:0] InpWord2;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        txReady = 1'b0;
    logic [31:0] rxData = '0;
    logic        rxValid = 1'b0;
    logic        rx_ready;
    logic        overflow;

    int nTests = 0;
    int nFail  = 0;

    // model state
    logic [31:0] mQ[$];
    logic        mOvf, mRxFull, mTogTx, mTogAck;
    logic [31:0] mRxWord;
    logic [31:0] dutEmitted[$];

    proc_io_mailbox #(.dataW(32), .FifoDepth(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .OutWord1(ow1), .OutWord2(ow2),
        .InpWord1(InpWord1), .InpWord2(InpWord2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txReady),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rx_ready),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareAll();
        logic [31:0] expStat;
        int sz;
        sz = mQ.size();
        expStat = {24'b0, 4'(sz), mTogTx, mOvf, (sz == DEPTH), mRxFull};
        checkVal("tx_valid", {31'b0, tx_valid}, {31'b0, (sz != 0)});
        if (sz != 0) checkVal("tx_data", tx_data, mQ[0]);
        checkVal("overflow", {31'b0, overflow}, {31'b0, mOvf});
        checkVal("rx_ready", {31'b0, rx_ready}, {31'b0, !mRxFull});
        checkVal("InpWord1", InpWord1, mRxWord);
        checkVal("InpWord2", InpWord2, expStat);
    endtask

    // Advance the model across one edge using the currently driven inputs,
    // then let the DUT take the same edge and compare.
    task automatic cycle();
        logic push, ack, pop, drop;
        push = ow2[31] != mTogTx;
        ack  = ow2[30] != mTogAck;
        pop  = (mQ.size() != 0) && txReady;
        drop = 1'b0;
        if (tx_valid && txReady) dutEmitted.push_back(tx_data);
        if (pop) void'(mQ.pop_front());
        if (push) begin
            if (mQ.size() < DEPTH) mQ.push_back(ow1);
            else drop = 1'b1;
        end
        if (drop) mOvf = 1'b1;
        else if (ow2[29]) mOvf = 1'b0;
        if (rxValid && !mRxFull) begin
            mRxWord = rxData;
            mRxFull = 1'b1;
        end else if (ack && mRxFull) begin
            mRxFull = 1'b0;
        end
        mTogTx  = ow2[31];
        mTogAck = ow2[30];
        @(posedge clock);
        #1;
        compareAll();
    endtask

    task automatic randInputs();
        ow1     = $urandom;
        ow2     = $urandom;
        txReady = 1'($urandom_range(0, 1));
        rxValid = 1'($urandom_range(0, 1));
        rxData  = $urandom;
    endtask

    task automatic checkResetOuts();
        checkVal("rst_InpWord1", InpWord1, 32'h0);
        checkVal("rst_InpWord2", InpWord2, 32'h0);
        checkVal("rst_tx_data", tx_data, 32'h0);
        checkVal("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkVal("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        checkVal("rst_overflow", {31'b0, overflow}, 32'h0);
    endtask

    // Assert reset with random inputs; optionally park inputs quiet before release.
    task automatic doReset(input int n, input bit quiet);
        reset = 1'b0;
        randInputs();
        #1;
        checkResetOuts();
        repeat (n) begin
            @(posedge clock);
            #1;
            randInputs();
            #1;
            checkResetOuts();
        end
        if (quiet) begin
            ow1 = '0; ow2 = '0; txReady = 1'b0; rxValid = 1'b0;
        end
        mQ.delete();
        mOvf = 0; mRxFull = 0; mTogTx = 0; mTogAck = 0; mRxWord = '0;
        reset = 1'b1;
    endtask

    task automatic pushWord(input logic [31:0] v);
        ow1 = v;
        ow2[31] = ~ow2[31];
        cycle();
    endtask

    task automatic checkEmitted(input string tag, input logic [31:0] exp[$]);
        checkVal({tag, "_len"}, 32'(dutEmitted.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < dutEmitted.size(); i++)
            checkVal(tag, dutEmitted[i], exp[i]);
    endtask

    initial begin
        logic [31:0] expQ[$];
        int nxt;

        doReset(4, 1'b1);

        // TX ordering
        txReady = 1'b0;
        pushWord(32'h11); pushWord(32'h22); pushWord(32'h33); pushWord(32'h44);
        checkVal("ord_full", {31'b0, InpWord2[1]}, 32'h1);
        checkVal("ord_count", {28'b0, InpWord2[7:4]}, 32'h4);
        dutEmitted.delete();
        txReady = 1'b1;
        repeat (4) cycle();
        checkVal("ord_drained", {31'b0, tx_valid}, 32'h0);
        expQ = '{32'h11, 32'h22, 32'h33, 32'h44};
        checkEmitted("ord_seq", expQ);

        // Overflow, clear, clear coincident with a drop
        txReady = 1'b0;
        pushWord(32'hA1); pushWord(32'hA2); pushWord(32'hA3); pushWord(32'hA4);
        pushWord(32'h55);
        checkVal("ovf_set", {31'b0, overflow}, 32'h1);
        ow2[29] = 1'b1; cycle(); ow2[29] = 1'b0;
        checkVal("ovf_clr", {31'b0, overflow}, 32'h0);
        ow2[29] = 1'b1; pushWord(32'h77);
        checkVal("ovf_clr_vs_drop", {31'b0, overflow}, 32'h1);
        cycle(); ow2[29] = 1'b0;
        dutEmitted.delete();
        txReady = 1'b1;
        repeat (6) cycle();
        expQ = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        checkEmitted("ovf_seq", expQ);

        // Push and pop on the same edge while full
        txReady = 1'b0;
        pushWord(32'hB1); pushWord(32'hB2); pushWord(32'hB3); pushWord(32'hB4);
        dutEmitted.delete();
        txReady = 1'b1;
        pushWord(32'h66);
        checkVal("pp_count", {28'b0, InpWord2[7:4]}, 32'h4);
        checkVal("pp_ovf", {31'b0, overflow}, 32'h0);
        repeat (5) cycle();
        expQ = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'h66};
        checkEmitted("pp_seq", expQ);

        // RX handshake
        txReady = 1'b0;
        rxValid = 1'b1; rxData = 32'hDEADBEEF;
        cycle();
        checkVal("rx_word", InpWord1, 32'hDEADBEEF);
        checkVal("rx_full", {31'b0, InpWord2[0]}, 32'h1);
        checkVal("rx_busy", {31'b0, rx_ready}, 32'h0);
        rxData = 32'h1234;
        cycle(); cycle();
        checkVal("rx_hold", InpWord1, 32'hDEADBEEF);
        ow2[30] = ~ow2[30];
        cycle();
        checkVal("rx_ack", {31'b0, rx_ready}, 32'h1);
        cycle();
        checkVal("rx_next", InpWord1, 32'h1234);
        rxValid = 1'b0;
        ow2[30] = ~ow2[30];
        cycle();

        // Pointer wrap with random back-pressure
        dutEmitted.delete();
        nxt = 1;
        for (int c = 0; c < 300 && (nxt <= 20 || mQ.size() != 0); c++) begin
            txReady = 1'($urandom_range(0, 1));
            if (nxt <= 20 && mQ.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                ow1 = 32'(nxt);
                ow2[31] = ~ow2[31];
                nxt++;
            end
            cycle();
        end
        expQ.delete();
        for (int i = 1; i <= 20; i++) expQ.push_back(32'(i));
        checkEmitted("wrap_seq", expQ);
        checkVal("wrap_ovf", {31'b0, overflow}, 32'h0);

        // Random traffic with a mid-run reset
        for (int c = 0; c < 400; c++) begin
            if (c == 200) doReset(2, 1'b0);
            ow1     = $urandom;
            ow2     = $urandom;
            ow2[29] = ($urandom_range(0, 7) == 0);
            txReady = 1'($urandom_range(0, 1));
            rxValid = 1'($urandom_range(0, 1));
            rxData  = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
